tic_tac_toe_core: RTL
=====================

# tic_tac_toe_core

Sequential game-state engine for the tic-tac-toe datapath. It accepts one cell index per move, validates it, and maintains the registered board (`grid_state_marked`, `grid_state_x`) and whose turn it is. It feeds the combinational win checker `ticTacToeWin` and samples that checker's `someone_won` / `player_x_won` one cycle after each accepted move to decide win, draw or continue.

## Interface
- `X_STARTS`, default 1: value loaded into `player_x_turn` on reset and on new game.

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `new_game` in 1: synchronous restart of the board. Honoured in any state.
- `move_valid` in 1: a move request is present this cycle.
- `move_cell` in 4: target cell, 0–8, with index = row*3 + col.
- `someone_won` in 1: from the win checker, computed from this block's grid outputs.
- `player_x_won` in 1: from the win checker. Meaningful only when `someone_won` = 1.
- `grid_state_marked` out 9: 1 = cell occupied.
- `grid_state_x` out 9: 1 = X, 0 = O. Meaningful only where marked.
- `player_x_turn` out 1: 1 = X to move.
- `move_ready` out 1: high only in PLAY.
- `move_ack` out 1: one-cycle pulse when a move is accepted.
- `move_err` out 1: one-cycle pulse when a move is rejected.
- `game_over` out 1: high in OVER.
- `result` out 2: 00 undecided, 01 X won, 10 O won, 11 draw.
- `move_count` out 4: number of accepted moves, 0–9.

## Operation
- Reset values:
  - grid outputs 0
  - `player_x_turn` = `X_STARTS`
  - `move_count` 0
  - `result` 00
  - `game_over`, `move_ack`, `move_err` 0
  - state PLAY
- States are PLAY, CHECK and OVER.
- **PLAY**, on `move_valid`:
  - Legal move (`move_cell` ≤ 8 and cell unmarked):
    - set `grid_state_marked[move_cell]`
    - set `grid_state_x[move_cell]` = `player_x_turn`
    - `move_count` += 1
    - `move_ack` = 1 next cycle
    - go to CHECK
  - Illegal move (cell 9–15, or cell already marked):
    - `move_err` = 1 next cycle
    - board, turn and count unchanged
    - stay in PLAY
- **CHECK** (exactly one cycle):
  - `move_valid` is ignored: no ack, no err.
  - If `someone_won`: `result` = `player_x_won` ? 01 : 10, go to OVER. The turn is not toggled.
  - Else if `move_count` = 9: `result` = 11, go to OVER.
  - Else: toggle `player_x_turn`, go to PLAY.
- **OVER**:
  - `game_over` = 1.
  - Board and result are held.
  - Any `move_valid` pulses `move_err`.
- **`new_game`** in any state:
  - Next-cycle values are identical to reset.
  - Takes priority over `move_valid` in the same cycle: no ack/err is produced for that move.
- `reset` has priority over everything.
- The win checker is purely combinational on the registered grid outputs. No win evaluation happens inside this block.

## Timing
- Move accepted at edge N:
  - Grid and count update at N.
  - `move_ack` is high during cycle N..N+1.
  - State is CHECK during that cycle.
- Edge N+1:
  - `result`, `game_over` and `player_x_turn` update.
  - `move_ready` returns high in PLAY after N+1 if the game continues.
- Earliest next accepted move is at edge N+2, giving a throughput of one move per 2 cycles.
- `move_err` is high for exactly the cycle after the offending edge.
- `move_ack` and `move_err` are never high together.
- A `move_valid` held high across CHECK is evaluated again in the following PLAY cycle. The same cell, now occupied, gives `move_err`.

## Test plan
- **Reset**: assert `reset` 2 cycles → grid 0/0, `player_x_turn`=1, `move_count`=0, `result`=00, `game_over`=0, `move_ready`=1.
- **X row win**: X0, O3, X1, O4, X2, each with one idle cycle between moves.
  - Edge after X2's CHECK cycle gives `result`=01, `game_over`=1, `move_count`=5.
  - A further move pulses `move_err`.
- **O win**: X0, O3, X1, O4, X8, O5.
  - `result`=10, `player_x_turn` stays 0, `move_count`=6.
- **Draw**: X0, O1, X2, O4, X3, O5, X7, O6, X8.
  - `result`=11, `move_count`=9, `grid_state_marked`=0x1FF, `grid_state_x`=0x18D.
- **Illegal moves**:
  - X4 accepted, then O4 → `move_err` pulse, grid unchanged, `player_x_turn`=0.
  - `move_cell`=9 and =15 → `move_err`, no state change.
  - `move_valid` held through CHECK → no ack/err in CHECK, then `move_err` in PLAY.
- **Restart**:
  - `new_game` and `move_valid` asserted together mid-game → board cleared, no `move_ack`.
  - `new_game` in OVER → PLAY, `result`=00.
  - `reset` during CHECK → all reset values next cycle.

Source files
------------

// File: rtl/tic_tac_toe_core_if.sv
// Move handshake between a move source (master) and the game-state engine (slave).
interface tic_tac_toe_core_if;
    logic       move_valid;
    logic [3:0] move_cell;
    logic       move_ready;
    logic       move_ack;
    logic       move_err;

    modport master (
        output move_valid,
        output move_cell,
        input  move_ready,
        input  move_ack,
        input  move_err
    );

    modport slave (
        input  move_valid,
        input  move_cell,
        output move_ready,
        output move_ack,
        output move_err
    );
endinterface

// File: rtl/tic_tac_toe_core.sv
// Tic-tac-toe game-state engine: validates moves, holds the board and turn,
// and resolves win/draw from an external combinational win checker.
//
// state | meaning
// PLAY  | waiting for a move; move_ready high
// CHECK | one cycle after an accepted move; win checker sampled
// OVER  | game decided; board and result held, moves rejected
module tic_tac_toe_core #(
    parameter bit X_STARTS = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_game,
    tic_tac_toe_core_if.slave         mv,
    input  logic                      someone_won,
    input  logic                      player_x_won,
    output logic [8:0]                grid_state_marked,
    output logic [8:0]                grid_state_x,
    output logic                      player_x_turn,
    output logic                      game_over,
    output logic [1:0]                result,
    output logic [3:0]                move_count
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] marked_q, marked_d;
    logic [8:0] x_q, x_d;
    logic       turn_q, turn_d;
    logic [3:0] count_q, count_d;
    logic [1:0] result_q, result_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    logic [8:0] cell_onehot;
    logic       cell_legal;

    // Cells 9..15 shift out of the 9-bit vector; the range check covers them.
    assign cell_onehot = 9'd1 << mv.move_cell;
    assign cell_legal  = (mv.move_cell <= 4'd8) && ((marked_q & cell_onehot) == 9'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLAY;
            marked_q <= 9'd0;
            x_q      <= 9'd0;
            turn_q   <= X_STARTS;
            count_q  <= 4'd0;
            result_q <= 2'b00;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            marked_q <= marked_d;
            x_q      <= x_d;
            turn_q   <= turn_d;
            count_q  <= count_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        marked_d = marked_q;
        x_d      = x_q;
        turn_d   = turn_q;
        count_d  = count_q;
        result_d = result_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        if (new_game) begin
            state_d  = PLAY;
            marked_d = 9'd0;
            x_d      = 9'd0;
            turn_d   = X_STARTS;
            count_d  = 4'd0;
            result_d = 2'b00;
        end else begin
            case (state_q)
                PLAY: begin
                    if (mv.move_valid) begin
                        if (cell_legal) begin
                            marked_d = marked_q | cell_onehot;
                            x_d      = turn_q ? (x_q | cell_onehot) : (x_q & ~cell_onehot);
                            count_d  = count_q + 4'd1;
                            ack_d    = 1'b1;
                            state_d  = CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (someone_won) begin
                        result_d = player_x_won ? 2'b01 : 2'b10;
                        state_d  = OVER;
                    end else if (count_q == 4'd9) begin
                        result_d = 2'b11;
                        state_d  = OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = PLAY;
                    end
                end
                OVER: begin
                    if (mv.move_valid) err_d = 1'b1;
                end
                default: state_d = PLAY;
            endcase
        end
    end

    always_comb begin
        mv.move_ready = (state_q == PLAY);
        game_over     = (state_q == OVER);
    end

    assign mv.move_ack        = ack_q;
    assign mv.move_err        = err_q;
    assign grid_state_marked  = marked_q;
    assign grid_state_x       = x_q;
    assign player_x_turn      = turn_q;
    assign result             = result_q;
    assign move_count         = count_q;

endmodule
